// File: rtl/systolic_pkg.sv
// Shared defaults and load-target encodings for the systolic operand feeder.
// Also derives the load address width from the array geometry.
package systolic_pkg;

    localparam int ROWS_DEF   = 4;
    localparam int COLS_DEF   = 4;
    localparam int K_DEF      = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    // One spare code so the first out-of-range address (buffer size) is
    // representable and can be rejected rather than aliasing onto word 0.
    function automatic int addr_w(input int rows, input int cols, input int k);
        int m;
        m = (rows > cols) ? rows : cols;
        return $clog2(m * k + 1);
    endfunction

endpackage

// File: rtl/skew_line.sv
// Data+valid delay line of DEPTH register stages feeding one array lane.
// busy reports any valid word still held anywhere in the line.
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign busy      = |valid_q;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand buffers plus per-lane skew lines that stream A columns west and
// B rows north into a systolic array, one k-slice per valid_src cycle.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int K      = K_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int AW    = addr_w(ROWS, COLS, K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic                     load_sel,
    input  logic [AW-1:0]            load_addr,
    input  logic [DATA_W-1:0]        load_data,
    output logic                     load_err,
    input  logic                     valid_src,
    output logic [ROWS*DATA_W-1:0]   a_west,
    output logic [ROWS-1:0]          a_valid,
    output logic [COLS*DATA_W-1:0]   b_north,
    output logic [COLS-1:0]          b_valid,
    output logic                     feeding
);

    localparam int KCW = $clog2(K + 1);
    localparam int KIW = (K > 1) ? $clog2(K) : 1;

    logic [DATA_W-1:0] a_buf [ROWS][K];
    logic [DATA_W-1:0] b_buf [COLS][K];

    logic [KCW-1:0] kcnt;
    logic [KIW-1:0] kidx;
    logic           inject;
    logic           in_range;
    logic           wr_ok;
    logic [ROWS-1:0] a_busy;
    logic [COLS-1:0] b_busy;

    assign inject   = valid_src && (kcnt < KCW'(K));
    assign kidx     = kcnt[KIW-1:0];
    assign in_range = (load_sel == SEL_B) ? (load_addr < AW'(COLS * K))
                                          : (load_addr < AW'(ROWS * K));
    assign wr_ok    = load_en && in_range && !feeding;

    // Operand storage survives reset so a feed can be replayed after abort.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < K; k++) begin
                    if (load_sel == SEL_A && load_addr == AW'(r * K + k)) begin
                        a_buf[r][k] <= load_data;
                    end
                end
            end
            for (int c = 0; c < COLS; c++) begin
                for (int k = 0; k < K; k++) begin
                    if (load_sel == SEL_B && load_addr == AW'(c * K + k)) begin
                        b_buf[c][k] <= load_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kcnt     <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_en && !(in_range && !feeding);
            if (!valid_src) begin
                kcnt <= '0;
            end else if (kcnt < KCW'(K)) begin
                kcnt <= kcnt + 1'b1;
            end
        end
    end

    // Lane i gets i+1 stages so the wavefront enters the array diagonally.
    for (genvar r = 0; r < ROWS; r++) begin : g_a
        skew_line #(
            .DEPTH  (r + 1),
            .DATA_W (DATA_W)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .in_data   (inject ? a_buf[r][kidx] : '0),
            .in_valid  (inject),
            .out_data  (a_west[r*DATA_W +: DATA_W]),
            .out_valid (a_valid[r]),
            .busy      (a_busy[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b
        skew_line #(
            .DEPTH  (c + 1),
            .DATA_W (DATA_W)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .in_data   (inject ? b_buf[c][kidx] : '0),
            .in_valid  (inject),
            .out_data  (b_north[c*DATA_W +: DATA_W]),
            .out_valid (b_valid[c]),
            .busy      (b_busy[c])
        );
    end

    assign feeding = |{a_busy, b_busy};

endmodule
